// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide engine.
// Latency: none (declarations only).
// Backpressure: not applicable.
// Contents: default operand width, op encoding, sequencer state enum.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/addsub.sv
// Combinational W-bit adder/subtractor shared by the Booth and non-restoring steps.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: x, y operands; sub selects x-y (1) or x+y (0); s result, modulo 2^W.
module addsub #(
   parameter int W = 33
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         sub,
   output logic [W-1:0] s
);

   assign s = sub ? (x - y) : (x + y);

endmodule

// File: rtl/mul_div_unit.sv
// Signed WIDTHxWIDTH multiply (radix-2 Booth) and WIDTH/WIDTH divide (non-restoring).
// Latency: done WIDTH+1 edges after the start edge; divide-by-zero done 1 edge after it.
// Backpressure: start is only sampled in IDLE; requests while busy or in DONE are dropped.
// Ports: clk, rst_n (sync, active-low); start/op/a/b request; busy, done, div_zero status;
//        zhigh/zlow result (MUL: product hi/lo, DIV: remainder/quotient), held until replaced.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] zhigh,
   output logic [WIDTH-1:0] zlow
);

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             op_r;
   logic             sa;           // sign of a at capture
   logic             sb;           // sign of b at capture
   logic [WIDTH:0]   r;            // P_hi for MUL, partial remainder for DIV
   logic [WIDTH-1:0] q;            // P_lo for MUL, quotient bits for DIV
   logic             qm1;          // Booth q-1 bit
   logic [WIDTH:0]   m;            // sign-extended multiplicand or |b|

   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH:0]   r_sh;
   logic [WIDTH:0]   add_x;
   logic             add_sub;
   logic [WIDTH:0]   sum;
   logic [1:0]       pair;
   logic             booth_add;
   logic [2*WIDTH+1:0] booth_pre;
   logic [2*WIDTH+1:0] booth_sh;
   logic [WIDTH-1:0] rem_mag;

   // Magnitudes as unsigned WIDTH-bit values: the most negative input maps to 2^(WIDTH-1).
   assign abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
   assign abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

   assign r_sh = {r[WIDTH-1:0], q[WIDTH-1]};
   assign pair = {q[0], qm1};
   assign booth_add = (pair == 2'b01) || (pair == 2'b10);

   // One adder serves the Booth step, the non-restoring step and the final restore.
   always_comb begin
      add_x   = r;
      add_sub = 1'b0;
      if (state == RUN) begin
         if (op_r == OP_DIV) begin
            add_x   = r_sh;
            add_sub = ~r[WIDTH];
         end else begin
            add_sub = (pair == 2'b10);
         end
      end
   end

   addsub #(.W(WIDTH + 1)) u_addsub (
      .x   (add_x),
      .y   (m),
      .sub (add_sub),
      .s   (sum)
   );

   // 33-bit P_hi keeps the intermediate value of (-2^31)*(-2^31) from wrapping.
   assign booth_pre = {(booth_add ? sum : r), q, qm1};
   assign booth_sh  = {booth_pre[2*WIDTH+1], booth_pre[2*WIDTH+1:1]};

   // In FINISH the adder computes r + |b|, i.e. the restored remainder.
   assign rem_mag = r[WIDTH] ? sum[WIDTH-1:0] : r[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         op_r     <= 1'b0;
         sa       <= 1'b0;
         sb       <= 1'b0;
         r        <= '0;
         q        <= '0;
         qm1      <= 1'b0;
         m        <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         zhigh    <= '0;
         zlow     <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op_r     <= op;
                  sa       <= a[WIDTH-1];
                  sb       <= b[WIDTH-1];
                  cnt      <= '0;
                  div_zero <= 1'b0;
                  busy     <= 1'b1;
                  r        <= '0;
                  qm1      <= 1'b0;
                  if (op == OP_DIV) begin
                     q     <= abs_a;
                     m     <= {1'b0, abs_b};
                     state <= (b == '0) ? FINISH : RUN;
                  end else begin
                     q     <= b;
                     m     <= {a[WIDTH-1], a};
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (op_r == OP_MUL) begin
                  {r, q, qm1} <= booth_sh;
               end else begin
                  r <= sum;
                  q <= {q[WIDTH-2:0], ~sum[WIDTH]};
               end
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= FINISH;
               end
            end
            FINISH: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
               if (op_r == OP_MUL) begin
                  zhigh <= r[WIDTH-1:0];
                  zlow  <= q;
               end else if (m == '0) begin
                  // q still holds |a|, so re-applying the sign recovers a.
                  zhigh    <= sa ? (~q + 1'b1) : q;
                  zlow     <= '1;
                  div_zero <= 1'b1;
               end else begin
                  zlow  <= (sa ^ sb) ? (~q + 1'b1) : q;
                  zhigh <= sa ? (~rem_mag + 1'b1) : rem_mag;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] zhigh;
   logic [31:0] zlow;

   int tests;
   int fails;

   mul_div_unit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .zhigh    (zhigh),
      .zlow     (zlow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain signed arithmetic on 64-bit integers.
   function automatic void model(input logic o, input logic [31:0] av, input logic [31:0] bv,
                                 output logic [31:0] hi, output logic [31:0] lo,
                                 output logic dz, output int lat);
      longint sa_l;
      longint sb_l;
      longint prod;
      longint quo;
      longint rem;
      sa_l = longint'($signed(av));
      sb_l = longint'($signed(bv));
      dz   = 1'b0;
      lat  = 34;
      if (o == 1'b0) begin
         prod = sa_l * sb_l;
         hi   = prod[63:32];
         lo   = prod[31:0];
      end else if (bv == 32'd0) begin
         hi  = av;
         lo  = 32'hFFFF_FFFF;
         dz  = 1'b1;
         lat = 2;
      end else begin
         quo = sa_l / sb_l;
         rem = sa_l % sb_l;
         hi  = rem[31:0];
         lo  = quo[31:0];
      end
   endfunction

   // Issue one request; repulse>0 re-asserts start at that cycle of the operation.
   task automatic run_op(input string tag, input logic o, input logic [31:0] av,
                         input logic [31:0] bv, input int repulse);
      logic [31:0] ehi;
      logic [31:0] elo;
      logic        edz;
      int          elat;
      int          lat;
      logic        got;
      model(o, av, bv, ehi, elo, edz, elat);
      @(negedge clk);
      op = o; a = av; b = bv; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      check({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
      check({tag, " div_zero_cleared"}, {31'd0, div_zero}, 32'd0);
      lat = 1;
      got = 1'b0;
      while (!got && lat < 100) begin
         if (lat == repulse) begin
            start = 1'b1;
            op = ~o;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done) got = 1'b1;
      end
      start = 1'b0;
      check({tag, " latency"}, lat, elat);
      check({tag, " zhigh"}, zhigh, ehi);
      check({tag, " zlow"}, zlow, elo);
      check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, edz});
      check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
      @(negedge clk);
      check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
      check({tag, " zlow_held"}, zlow, elo);
   endtask

   task automatic count_dones(input string tag, input int cycles);
      int n;
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done) n++;
      end
      check({tag, " no_extra_done"}, n, 0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        ro;
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset div_zero", {31'd0, div_zero}, 32'd0);
      check("reset zhigh", zhigh, 32'd0);
      check("reset zlow", zlow, 32'd0);
      rst_n = 1'b1;

      // start low in IDLE does nothing
      count_dones("idle", 5);
      check("idle busy", {31'd0, busy}, 32'd0);

      run_op("mul 7*-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 0);
      run_op("mul min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
      run_op("mul -1*-1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("div 100/7", 1'b1, 32'd100, 32'd7, 0);
      run_op("div 5/0", 1'b1, 32'd5, 32'd0, 0);
      run_op("mul after div0", 1'b0, 32'd12, 32'd34, 0);
      run_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 10);
      count_dones("repulse", 40);
      run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
      run_op("div min/min", 1'b1, 32'h8000_0000, 32'h8000_0000, 0);
      run_op("div -9/0", 1'b1, 32'hFFFF_FFF7, 32'd0, 0);

      // reset in the middle of a multiply
      @(negedge clk);
      op = 1'b0; a = 32'h1234_5678; b = 32'h0FED_CBA9; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst busy", {31'd0, busy}, 32'd0);
      check("midrst done", {31'd0, done}, 32'd0);
      check("midrst zhigh", zhigh, 32'd0);
      check("midrst zlow", zlow, 32'd0);
      check("midrst div_zero", {31'd0, div_zero}, 32'd0);
      rst_n = 1'b1;
      count_dones("midrst", 40);
      run_op("mul after reset", 1'b0, 32'h1234_5678, 32'h0FED_CBA9, 0);

      for (int i = 0; i < 40; i++) begin
         ro = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = $urandom;
            1: rb = 32'($urandom_range(0, 20)) - 32'd10;
            2: rb = {16'd0, 16'($urandom)};
            default: rb = (ro && i % 8 == 0) ? 32'd0 : $urandom;
         endcase
         if (i % 5 == 0) ra = 32'($urandom_range(0, 3)) + 32'h7FFF_FFFE;
         run_op(ro ? "rand div" : "rand mul", ro, ra, rb, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
